// File: rtl/uart_tx_param.sv
// uart_tx_param
// Buffered UART transmitter. Words are queued in a small power-of-two FIFO
// and sent as frames: a start bit, DATA_BITS data bits LSB first, an
// optional parity bit, then one or two stop bits. The parity mode and the
// stop-bit count are captured when a word leaves the FIFO. They stay fixed
// for the whole frame.
//
// Parameters
//   CLKS_PER_BIT  clocks per serial bit (>= 2)
//   DATA_BITS     data bits per frame (5..9)
//   FIFO_DEPTH    transmit FIFO entries (power of two, >= 2)
//
// Ports
//   i_Clock        sole clock, rising edge
//   i_Reset        synchronous active-high reset; empties the FIFO and aborts any frame
//   i_Tx_DV        write strobe for i_Tx_Byte; accepted only while o_Tx_Ready=1
//   i_Tx_Byte      data word to queue
//   i_Parity_Mode  00 none, 01 odd, 10 even, 11 none
//   i_Two_Stop     1 = two stop bits, 0 = one
//   o_Tx_Ready     FIFO not full
//   o_Fifo_Count   number of queued words
//   o_Tx_Active    frame in progress
//   o_Tx_Serial    registered serial line, idle high
//   o_Tx_Done      one-cycle pulse per completed frame
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                               i_Clock,
  input  logic                               i_Reset,
  input  logic                               i_Tx_DV,
  input  logic [DATA_BITS-1:0]               i_Tx_Byte,
  input  logic [1:0]                         i_Parity_Mode,
  input  logic                               i_Two_Stop,
  output logic                               o_Tx_Ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_Fifo_Count,
  output logic                               o_Tx_Active,
  output logic                               o_Tx_Serial,
  output logic                               o_Tx_Done
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(DATA_BITS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // ------------------------------------------------------------------
  // Transmit FIFO
  // ------------------------------------------------------------------
  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [FCNT_W-1:0]    fifo_count_reg;

  state_t               state_reg;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 wr_en;
  logic                 pop_en;

  assign fifo_full  = (fifo_count_reg == FIFO_FULL);
  assign fifo_empty = (fifo_count_reg == '0);

  // A write arriving while the FIFO is full is dropped. This holds even if
  // a pop happens on the same edge, so the count never goes past FIFO_DEPTH.
  assign wr_en  = i_Tx_DV && !fifo_full && !i_Reset;
  // The head word leaves the FIFO on the same edge that starts a frame.
  assign pop_en = (state_reg == IDLE) && !fifo_empty;

  // Storage has no reset. The empty count already makes stale entries
  // unreachable.
  always_ff @(posedge i_Clock) begin
    if (wr_en) begin
      fifo_mem[wr_ptr_reg] <= i_Tx_Byte;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      // Pointers wrap naturally because the depth is a power of two.
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({wr_en, pop_en})
        2'b10:   fifo_count_reg <= fifo_count_reg + FCNT_W'(1);
        2'b01:   fifo_count_reg <= fifo_count_reg - FCNT_W'(1);
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Frame sequencer
  // ------------------------------------------------------------------
  logic [CNT_W-1:0]     clk_cnt_reg;
  logic [IDX_W-1:0]     bit_idx_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_bit_reg;
  logic                 parity_en_reg;
  logic                 two_stop_reg;
  logic                 stop_second_reg;
  logic                 serial_reg;
  logic                 active_reg;
  logic                 done_reg;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_reg       <= IDLE;
      clk_cnt_reg     <= '0;
      bit_idx_reg     <= '0;
      shift_reg       <= '0;
      parity_bit_reg  <= 1'b0;
      parity_en_reg   <= 1'b0;
      two_stop_reg    <= 1'b0;
      stop_second_reg <= 1'b0;
      serial_reg      <= 1'b1;
      active_reg      <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          serial_reg  <= 1'b1;
          clk_cnt_reg <= '0;
          if (pop_en) begin
            // Capture the word and its framing options at the pop. The start
            // bit goes onto the line at this same edge. That leaves exactly
            // one idle-high cycle after the previous stop bit.
            shift_reg       <= fifo_mem[rd_ptr_reg];
            parity_bit_reg  <= (^fifo_mem[rd_ptr_reg]) ^ (i_Parity_Mode == 2'b01);
            parity_en_reg   <= (i_Parity_Mode == 2'b01) || (i_Parity_Mode == 2'b10);
            two_stop_reg    <= i_Two_Stop;
            stop_second_reg <= 1'b0;
            serial_reg      <= 1'b0;
            active_reg      <= 1'b1;
            state_reg       <= START;
          end
        end

        START: begin
          if (clk_cnt_reg == CNT_LAST) begin
            clk_cnt_reg <= '0;
            bit_idx_reg <= '0;
            serial_reg  <= shift_reg[0];
            state_reg   <= DATA;
          end else begin
            clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
          end
        end

        DATA: begin
          if (clk_cnt_reg == CNT_LAST) begin
            clk_cnt_reg <= '0;
            if (bit_idx_reg == IDX_LAST) begin
              if (parity_en_reg) begin
                serial_reg <= parity_bit_reg;
                state_reg  <= PARITY;
              end else begin
                serial_reg      <= 1'b1;
                stop_second_reg <= 1'b0;
                state_reg       <= STOP;
              end
            end else begin
              // Shift right so the next bit is always at position 0. Bit 1
              // of the current value is that next bit.
              bit_idx_reg <= bit_idx_reg + IDX_W'(1);
              shift_reg   <= shift_reg >> 1;
              serial_reg  <= shift_reg[1];
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
          end
        end

        PARITY: begin
          if (clk_cnt_reg == CNT_LAST) begin
            clk_cnt_reg     <= '0;
            serial_reg      <= 1'b1;
            stop_second_reg <= 1'b0;
            state_reg       <= STOP;
          end else begin
            clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
          end
        end

        STOP: begin
          // The bit counter covers only one bit time. With two stop bits,
          // stop_second_reg marks the second pass, so the counter never needs
          // to reach 2*CLKS_PER_BIT.
          if (clk_cnt_reg == CNT_LAST) begin
            clk_cnt_reg <= '0;
            if (two_stop_reg && !stop_second_reg) begin
              stop_second_reg <= 1'b1;
            end else begin
              stop_second_reg <= 1'b0;
              active_reg      <= 1'b0;
              done_reg        <= 1'b1;
              state_reg       <= IDLE;
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign o_Tx_Ready   = !fifo_full;
  assign o_Fifo_Count = fifo_count_reg;
  assign o_Tx_Active  = active_reg;
  assign o_Tx_Serial  = serial_reg;
  assign o_Tx_Done    = done_reg;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param
// Directed bench for uart_tx_param. It uses two instances, both with
// CLKS_PER_BIT=4 and FIFO_DEPTH=4: one with DATA_BITS=8 and one with
// DATA_BITS=5. A logger records the serial, active and done outputs on every
// falling edge. Each test finds the frame start in that log and compares the
// recorded window against expected per-cycle waveforms. The expected
// waveforms come from the frame layout: start, data LSB first, optional
// parity, stop bits, then a one-cycle done pulse.
module tb_uart_tx_param;

  localparam int CPB   = 4;
  localparam int LOG_N = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic       dv;
  logic [7:0] tx_byte;
  logic [1:0] mode;
  logic       two;
  logic       ready;
  logic [2:0] count;
  logic       active;
  logic       serial;
  logic       done;

  logic       dv5;
  logic [4:0] byte5;
  logic       ready5;
  logic [2:0] count5;
  logic       active5;
  logic       serial5;
  logic       done5;

  always #5 clk = ~clk;

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .FIFO_DEPTH(4)) dut (
    .i_Clock       (clk),
    .i_Reset       (rst),
    .i_Tx_DV       (dv),
    .i_Tx_Byte     (tx_byte),
    .i_Parity_Mode (mode),
    .i_Two_Stop    (two),
    .o_Tx_Ready    (ready),
    .o_Fifo_Count  (count),
    .o_Tx_Active   (active),
    .o_Tx_Serial   (serial),
    .o_Tx_Done     (done)
  );

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .FIFO_DEPTH(4)) dut5 (
    .i_Clock       (clk),
    .i_Reset       (rst),
    .i_Tx_DV       (dv5),
    .i_Tx_Byte     (byte5),
    .i_Parity_Mode (mode),
    .i_Two_Stop    (two),
    .o_Tx_Ready    (ready5),
    .o_Fifo_Count  (count5),
    .o_Tx_Active   (active5),
    .o_Tx_Serial   (serial5),
    .o_Tx_Done     (done5)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Falling-edge log of both instances.
  int   cyc = 0;
  logic ser_log  [0:LOG_N-1];
  logic act_log  [0:LOG_N-1];
  logic done_log [0:LOG_N-1];
  logic ser5_log [0:LOG_N-1];
  logic act5_log [0:LOG_N-1];
  logic done5_log[0:LOG_N-1];

  always @(negedge clk) begin
    if (cyc < LOG_N) begin
      ser_log[cyc]   <= serial;
      act_log[cyc]   <= active;
      done_log[cyc]  <= done;
      ser5_log[cyc]  <= serial5;
      act5_log[cyc]  <= active5;
      done5_log[cyc] <= done5;
    end
    cyc <= cyc + 1;
  end

  // Observed and expected windows, indexed by cycle offset from frame start.
  logic [0:255] obs_ser, obs_act, obs_done;
  logic [0:255] exp_ser, exp_act, exp_done;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns the log index that the next falling edge will record.
  task automatic mark(output int m);
    @(posedge clk);
    m = cyc;
  endtask

  task automatic find_start(input int which, input int from, input int limit, output int s);
    s = -1;
    for (int i = from; i < from + limit && i < LOG_N; i++) begin
      if (s < 0 && ((which == 0 && act_log[i] === 1'b1) ||
                    (which == 1 && act5_log[i] === 1'b1)))
        s = i;
    end
  endtask

  task automatic gather(input int which, input int s, input int n);
    obs_ser  = '1;
    obs_act  = '0;
    obs_done = '0;
    for (int i = 0; i < n && i < 256 && s + i < LOG_N; i++) begin
      if (which == 0) begin
        obs_ser[i]  = ser_log[s+i];
        obs_act[i]  = act_log[s+i];
        obs_done[i] = done_log[s+i];
      end else begin
        obs_ser[i]  = ser5_log[s+i];
        obs_act[i]  = act5_log[s+i];
        obs_done[i] = done5_log[s+i];
      end
    end
  endtask

  task automatic clear_exp();
    exp_ser  = '1;
    exp_act  = '0;
    exp_done = '0;
  endtask

  // Expected waveform of one frame starting at offset off.
  task automatic build_frame(input logic [8:0] data, input int nbits, input logic [1:0] pmode,
                             input logic two_stop, input int off, output int next_off);
    logic [0:15] seq;
    logic        par;
    int          nb;
    seq = '1;
    nb  = 0;
    seq[nb] = 1'b0;
    nb++;
    par = (pmode == 2'b01);
    for (int i = 0; i < nbits; i++) begin
      seq[nb] = data[i];
      par     = par ^ data[i];
      nb++;
    end
    if (pmode == 2'b01 || pmode == 2'b10) begin
      seq[nb] = par;
      nb++;
    end
    seq[nb] = 1'b1;
    nb++;
    if (two_stop) begin
      seq[nb] = 1'b1;
      nb++;
    end
    for (int c = 0; c < nb * CPB; c++) begin
      exp_ser[off+c]  = seq[c/CPB];
      exp_act[off+c]  = 1'b1;
      exp_done[off+c] = 1'b0;
    end
    exp_ser[off+nb*CPB]  = 1'b1;
    exp_act[off+nb*CPB]  = 1'b0;
    exp_done[off+nb*CPB] = 1'b1;
    next_off = off + nb * CPB + 1;
  endtask

  function automatic int first_diff();
    for (int i = 0; i < 256; i++) begin
      if (obs_ser[i] !== exp_ser[i] || obs_act[i] !== exp_act[i] || obs_done[i] !== exp_done[i])
        return i;
    end
    return 0;
  endfunction

  // Queue one word into the 8-bit instance. The call returns at the falling
  // edge after the write edge.
  task automatic write_word(input logic [7:0] b, input logic [1:0] pm, input logic ts);
    tx_byte = b;
    mode    = pm;
    two     = ts;
    dv      = 1'b1;
    @(negedge clk);
    dv = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; dv = 1'b1; tx_byte = 8'h5A; mode = 2'b00; two = 1'b0;
    dv5 = 1'b1; byte5 = 5'h0A;
    tick(3);
    n_checks++;
    if (serial !== 1'b1) begin n_fail++; $display("FAIL reset_serial: got %b required 1", serial); end
    n_checks++;
    if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b required 0", active); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
    n_checks++;
    if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count_dv_ignored: got %0d required 0", count); end
    n_checks++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", ready); end
    n_checks++;
    if ({serial5, count5, ready5} !== {1'b1, 3'd0, 1'b1}) begin
      n_fail++; $display("FAIL reset_dut5: got ser=%b cnt=%0d rdy=%b required 1/0/1", serial5, count5, ready5);
    end
    rst = 1'b0; dv = 1'b0; dv5 = 1'b0;
    tick(3);
  endtask

  task automatic test_basic_frame();
    int m, s, nx, d;
    logic [0:9] pat, got;
    pat = 10'b0101001011;
    mark(m);
    @(negedge clk);
    write_word(8'hA5, 2'b00, 1'b0);
    n_checks++;
    if (count !== 3'd1) begin n_fail++; $display("FAIL basic_queued_count: got %0d required 1", count); end
    n_checks++;
    if (active !== 1'b0) begin n_fail++; $display("FAIL basic_not_yet_active: got %b required 0", active); end
    tick(60);
    find_start(0, m, 100, s);
    n_checks++;
    if (s != m + 2) begin
      n_fail++; $display("FAIL basic_start_latency: got %0d cycles required 2", s - m);
    end else begin
      clear_exp();
      build_frame(9'h0A5, 8, 2'b00, 1'b0, 0, nx);
      gather(0, s, nx + 1);
      n_checks++;
      if ({obs_ser, obs_act, obs_done} !== {exp_ser, exp_act, exp_done}) begin
        n_fail++; d = first_diff();
        $display("FAIL basic_frame: ser/act/done got %b%b%b required %b%b%b at cycle %0d",
                 obs_ser[d], obs_act[d], obs_done[d], exp_ser[d], exp_act[d], exp_done[d], d);
      end
      for (int k = 0; k < 10; k++) got[k] = obs_ser[4*k+2];
      n_checks++;
      if (got !== pat) begin n_fail++; $display("FAIL basic_bit_pattern: got %b required %b", got, pat); end
    end
  endtask

  task automatic test_parity(input logic [1:0] pm, input logic ts, input logic exp_par, input int exp_len);
    int m, s, nx, d;
    mark(m);
    @(negedge clk);
    write_word(8'hA5, pm, ts);
    tick(70);
    find_start(0, m, 100, s);
    n_checks++;
    if (s < 0) begin
      n_fail++; $display("FAIL parity_start mode=%b two=%b: got no frame required one", pm, ts);
    end else begin
      clear_exp();
      build_frame(9'h0A5, 8, pm, ts, 0, nx);
      gather(0, s, nx + 1);
      n_checks++;
      if ({obs_ser, obs_act, obs_done} !== {exp_ser, exp_act, exp_done}) begin
        n_fail++; d = first_diff();
        $display("FAIL parity_frame mode=%b two=%b: got %b%b%b required %b%b%b at cycle %0d", pm, ts,
                 obs_ser[d], obs_act[d], obs_done[d], exp_ser[d], exp_act[d], exp_done[d], d);
      end
      n_checks++;
      if (obs_ser[38] !== exp_par) begin
        n_fail++; $display("FAIL parity_bit mode=%b: got %b required %b", pm, obs_ser[38], exp_par);
      end
      n_checks++;
      if (obs_done[exp_len] !== 1'b1 || obs_act[exp_len-1] !== 1'b1) begin
        n_fail++; $display("FAIL parity_frame_len mode=%b two=%b: done=%b act=%b required done after %0d cycles",
                           pm, ts, obs_done[exp_len], obs_act[exp_len-1], exp_len);
      end
    end
  endtask

  task automatic test_back_to_back();
    int m, s, off, d;
    logic [7:0] words [6];
    logic [2:0] exp_cnt [6];
    words   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    mark(m);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      tx_byte = words[i];
      mode    = 2'b00;
      two     = 1'b0;
      dv      = 1'b1;
      @(negedge clk);
      n_checks++;
      if (count !== exp_cnt[i]) begin
        n_fail++; $display("FAIL fifo_count after write %0d: got %0d required %0d", i, count, exp_cnt[i]);
      end
    end
    dv = 1'b0;
    n_checks++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL fifo_full_ready: got %b required 0", ready); end
    tick(230);
    n_checks++;
    if (count !== 3'd0) begin n_fail++; $display("FAIL fifo_drained: got %0d required 0", count); end
    find_start(0, m, 100, s);
    n_checks++;
    if (s < 0) begin
      n_fail++; $display("FAIL fifo_start: got no frame required one");
    end else begin
      clear_exp();
      off = 0;
      for (int i = 0; i < 5; i++) build_frame({1'b0, words[i]}, 8, 2'b00, 1'b0, off, off);
      gather(0, s, off + 1);
      n_checks++;
      if ({obs_ser, obs_act, obs_done} !== {exp_ser, exp_act, exp_done}) begin
        n_fail++; d = first_diff();
        $display("FAIL fifo_frames: got %b%b%b required %b%b%b at cycle %0d",
                 obs_ser[d], obs_act[d], obs_done[d], exp_ser[d], exp_act[d], exp_done[d], d);
      end
    end
  endtask

  task automatic test_five_bits();
    int m, s, nx, d;
    logic [0:6] pat, got;
    pat = 7'b0110011;
    mark(m);
    @(negedge clk);
    byte5 = 5'h13; mode = 2'b00; two = 1'b0; dv5 = 1'b1;
    @(negedge clk);
    dv5 = 1'b0;
    tick(40);
    find_start(1, m, 100, s);
    n_checks++;
    if (s < 0) begin
      n_fail++; $display("FAIL five_start: got no frame required one");
    end else begin
      clear_exp();
      build_frame(9'h013, 5, 2'b00, 1'b0, 0, nx);
      gather(1, s, nx + 1);
      n_checks++;
      if ({obs_ser, obs_act, obs_done} !== {exp_ser, exp_act, exp_done}) begin
        n_fail++; d = first_diff();
        $display("FAIL five_frame: got %b%b%b required %b%b%b at cycle %0d",
                 obs_ser[d], obs_act[d], obs_done[d], exp_ser[d], exp_act[d], exp_done[d], d);
      end
      for (int k = 0; k < 7; k++) got[k] = obs_ser[4*k+2];
      n_checks++;
      if (got !== pat || obs_done[28] !== 1'b1) begin
        n_fail++; $display("FAIL five_bit_pattern: got %b done28=%b required %b done28=1", got, obs_done[28], pat);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int m, seen_done, seen_act;
    mark(m);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tx_byte = 8'hC0 + 8'(i); mode = 2'b00; two = 1'b0; dv = 1'b1;
      @(negedge clk);
    end
    dv = 1'b0;
    tick(13);
    n_checks++;
    if (count !== 3'd2 || active !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_setup: got cnt=%0d act=%b required cnt=2 act=1", count, active);
    end
    rst = 1'b1; dv = 1'b1; tx_byte = 8'hFF;
    @(negedge clk);
    rst = 1'b0; dv = 1'b0;
    n_checks++;
    if ({serial, active, count, ready, done} !== {1'b1, 1'b0, 3'd0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL rstmid_state: got ser=%b act=%b cnt=%0d rdy=%b done=%b required 1/0/0/1/0",
                         serial, active, count, ready, done);
    end
    mark(m);
    tick(60);
    seen_done = 0;
    seen_act  = 0;
    for (int i = m; i < m + 60; i++) begin
      if (done_log[i] !== 1'b0) seen_done++;
      if (act_log[i] !== 1'b0)  seen_act++;
    end
    n_checks++;
    if (seen_done != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses required 0", seen_done); end
    n_checks++;
    if (seen_act != 0) begin n_fail++; $display("FAIL rstmid_flushed: got %0d active cycles required 0", seen_act); end
  endtask

  task automatic test_mode_change();
    int m, s, off, d;
    mark(m);
    @(negedge clk);
    tx_byte = 8'hA5; mode = 2'b10; two = 1'b0; dv = 1'b1;
    @(negedge clk);
    @(negedge clk);
    dv = 1'b0;
    tick(10);
    mode = 2'b01;
    tick(100);
    mode = 2'b00;
    find_start(0, m, 100, s);
    n_checks++;
    if (s < 0) begin
      n_fail++; $display("FAIL mode_start: got no frame required one");
    end else begin
      clear_exp();
      off = 0;
      build_frame(9'h0A5, 8, 2'b10, 1'b0, off, off);
      build_frame(9'h0A5, 8, 2'b01, 1'b0, off, off);
      gather(0, s, off + 1);
      n_checks++;
      if ({obs_ser, obs_act, obs_done} !== {exp_ser, exp_act, exp_done}) begin
        n_fail++; d = first_diff();
        $display("FAIL mode_frames: got %b%b%b required %b%b%b at cycle %0d",
                 obs_ser[d], obs_act[d], obs_done[d], exp_ser[d], exp_act[d], exp_done[d], d);
      end
      n_checks++;
      if (obs_ser[38] !== 1'b0 || obs_ser[45+38] !== 1'b1) begin
        n_fail++; $display("FAIL mode_parity: got first=%b second=%b required first=0 second=1",
                           obs_ser[38], obs_ser[45+38]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity(2'b10, 1'b0, 1'b0, 44);
    test_parity(2'b01, 1'b0, 1'b1, 44);
    test_parity(2'b01, 1'b1, 1'b1, 48);
    test_back_to_back();
    test_five_bits();
    test_reset_mid_frame();
    test_mode_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end of the test sequence");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, meaning clocks per serial bit (≥2).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (5..9).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning transmit FIFO entries (power of two, ≥2).
REQ-004 SHALL have port i_Clock  input  1  meaning sole clock, rising edge.
REQ-005 SHALL have port i_Reset  input  1  meaning reset, synchronous and active-high.
REQ-006 SHALL have port i_Tx_DV  input  1  meaning write strobe for i_Tx_Byte.
REQ-007 SHALL have port i_Tx_Byte  input  DATA_BITS  meaning data word to queue.
REQ-008 SHALL have port i_Parity_Mode  input  2  meaning 00 none, 01 odd, 10 even, 11 none.
REQ-009 SHALL have port i_Two_Stop  input  1  meaning 1 = two stop bits, 0 = one.
REQ-010 SHALL have port o_Tx_Ready  output  1  meaning FIFO not full, write accepted.
REQ-011 SHALL have port o_Fifo_Count  output  $clog2(FIFO_DEPTH+1)  meaning queued words.
REQ-012 SHALL have port o_Tx_Active  output  1  meaning frame in progress.
REQ-013 SHALL have port o_Tx_Serial  output  1  meaning registered serial line, idle high.
REQ-014 SHALL have port o_Tx_Done  output  1  meaning one-cycle pulse per completed frame.

Function
REQ-015 SHALL write i_Tx_Byte to the FIFO on a clock edge where i_Tx_DV=1 and o_Tx_Ready=1; writes with o_Tx_Ready=0 are dropped, with no state change.
REQ-016 SHALL permit a simultaneous write and pop when not full; o_Fifo_Count then remains unchanged.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP; the frame is LSB first.
REQ-018 SHALL, in IDLE with o_Fifo_Count>0, pop the head word on that edge, latch i_Parity_Mode and i_Two_Stop for the whole frame, set o_Tx_Active=1 and enter START.
REQ-019 SHALL hold each serial bit for exactly CLKS_PER_BIT cycles; the start bit (0) appears on o_Tx_Serial from the edge after the pop.
REQ-020 SHALL leave DATA after DATA_BITS bits, entering PARITY if mode is 01/10, else STOP.
REQ-021 SHALL drive parity = XOR of data bits (even) or its inverse (odd).
REQ-022 SHALL drive STOP high for CLKS_PER_BIT cycles, or 2×CLKS_PER_BIT when two stops are latched.
REQ-023 SHALL, on the last STOP cycle, return to IDLE, clear o_Tx_Active and pulse o_Tx_Done for exactly one cycle.
REQ-024 SHALL keep o_Tx_Serial high in IDLE; the minimum gap between back-to-back frames is 1 clock.
REQ-025 SHALL size the bit-clock counter to $clog2(CLKS_PER_BIT) bits and the bit index to $clog2(DATA_BITS) bits, with no wrap within a frame.
REQ-026 SHALL ignore input mode changes during a frame.

Reset
REQ-027 SHALL, when i_Reset=1 at an edge, including mid-frame, set state IDLE, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, empty the FIFO (o_Fifo_Count=0, o_Tx_Ready=1) and clear all counters.
REQ-028 SHALL ignore i_Tx_DV on a reset edge.

Verification
REQ-029 SHALL verify CLKS_PER_BIT=4, DATA_BITS=8, mode 00, one stop, write 0xA5 -> line 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles), then a single o_Tx_Done pulse.
REQ-030 SHALL verify 0xA5 with mode 10 -> parity bit 0; with mode 01 -> parity 1; with mode 01 and i_Two_Stop=1 -> 48-cycle frame.
REQ-031 SHALL verify FIFO_DEPTH=4 with 5 writes on consecutive cycles from idle -> all 5 accepted, o_Fifo_Count=4, o_Tx_Ready=0, sixth write dropped, five frames sent in order with 1-cycle gaps.
REQ-032 SHALL verify DATA_BITS=5 and write 0x13 -> line 0,1,1,0,0,1,1 (7 bits, 28 cycles).
REQ-033 SHALL verify i_Reset pulse mid-DATA with 2 words queued -> o_Tx_Serial=1, o_Tx_Active=0 and o_Fifo_Count=0 the next cycle, and no o_Tx_Done pulse.
REQ-034 SHALL verify i_Parity_Mode toggled mid-frame -> the current frame's parity is unchanged, and the next frame uses the new mode.
